// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard control unit:
// FSM state encoding and the register-index width.
package hazard_pkg;

  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

endpackage

// File: rtl/hazard_ctrl_detect.sv
// Load-use comparator: flags when the load in EX writes a register
// that the instruction in ID reads. x0 is never a true dependency.
module hazard_detect
  import hazard_pkg::*;
(
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_mem_read,
  output logic                 load_use
);

  // Match the EX destination against each source the ID instruction actually uses
  always_comb begin
    load_use = ex_mem_read && (ex_rd != '0) &&
               ((id_use_rs1 && (ex_rd == id_rs1)) ||
                (id_use_rs2 && (ex_rd == id_rs2)));
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline control unit for the 5-stage core. Drives load enables and
// bubble-insert controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
// Priority in RUN: mem_busy > branch_taken > load-use.
// Optional macro HAZARD_PERF_EN adds stall_cycles / flush_events counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_mem_read,
  input  logic                 branch_taken,
  input  logic                 mem_busy,
  output logic                 pc_load,
  output logic                 ifid_load,
  output logic                 idex_load,
  output logic                 exmem_load,
  output logic                 memwb_load,
  output logic                 ifid_flush,
  output logic                 idex_flush,
  output logic                 exmem_flush,
  output logic                 mem_timeout,
`ifdef HAZARD_PERF_EN
  output logic [31:0]          stall_cycles,
  output logic [31:0]          flush_events,
`endif
  output logic [1:0]           state
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             load_use;
  logic             run_rules;
  logic             branch_flush;
  logic             lu_stall;

  hazard_detect u_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .load_use    (load_use)
  );

  // State and wait counter registers; reset drops straight back to INIT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_INIT;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next state, wait counter and all pipeline controls
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    pc_load      = 1'b0;
    ifid_load    = 1'b0;
    idex_load    = 1'b0;
    exmem_load   = 1'b0;
    memwb_load   = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_flush  = 1'b0;
    run_rules    = 1'b0;
    branch_flush = 1'b0;
    lu_stall     = 1'b0;

    unique case (state_q)
      ST_INIT: begin
        {pc_load, ifid_load, idex_load, exmem_load, memwb_load} = 5'b11111;
        {ifid_flush, idex_flush, exmem_flush} = 3'b111;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (mem_busy) begin
          state_d    = ST_WAIT;
          wait_cnt_d = CNT_W'(1);
        end else begin
          run_rules  = 1'b1;
          wait_cnt_d = '0;
        end
      end
      ST_WAIT: begin
        if (mem_busy) begin
          if (wait_cnt_q == CNT_W'(MAX_WAIT)) begin
            state_d = ST_ERR;
          end else begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
          end
        end else begin
          // The exit cycle resolves whatever branch/load-use was held during the stall
          state_d    = ST_RUN;
          wait_cnt_d = '0;
          run_rules  = 1'b1;
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase

    if (run_rules) begin
      if (branch_taken) begin
        branch_flush = 1'b1;
        {pc_load, ifid_load, idex_load, exmem_load, memwb_load} = 5'b11111;
        {ifid_flush, idex_flush, exmem_flush} = 3'b111;
      end else if (load_use) begin
        lu_stall = 1'b1;
        {pc_load, ifid_load, idex_load, exmem_load, memwb_load} = 5'b00111;
        idex_flush = 1'b1;
      end else begin
        {pc_load, ifid_load, idex_load, exmem_load, memwb_load} = 5'b11111;
      end
    end

    // While reset is held every register is closed and primed with a bubble
    if (rst) begin
      {pc_load, ifid_load, idex_load, exmem_load, memwb_load} = 5'b00000;
      {ifid_flush, idex_flush, exmem_flush} = 3'b111;
      branch_flush = 1'b0;
      lu_stall     = 1'b0;
    end
  end

  assign mem_timeout = (state_q == ST_ERR);
  assign state       = state_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_events_q, flush_events_d;

  // Performance counter next values; both wrap naturally at 2^32
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    if ((state_q == ST_WAIT) || ((state_q == ST_RUN) && lu_stall)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
    if (branch_flush) begin
      flush_events_d = flush_events_q + 32'd1;
    end
  end

  // Performance counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline control unit for the 5-stage RISC-V core.
- Drives the load enables and bubble-insert (flush) controls of the PC register and of the IF/ID, ID/EX, EX/MEM and MEM/WB N_bit_reg stages.
- Resolves three hazard types:
  - load-use hazards;
  - taken-branch flushes, with branches resolved in MEM;
  - multi-cycle data-memory stalls, with a watchdog timeout.
- Sits beside the datapath and feeds every pipeline-register load input.

Parameters:
- MAX_WAIT, 16, max consecutive mem_busy cycles before timeout (≥2).
- CNT_W, 5, width of wait counter; must satisfy 2^CNT_W > MAX_WAIT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- id_rs1  in  5  rs1 of instruction in ID.
- id_rs2  in  5  rs2 of instruction in ID.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- ex_rd  in  5  destination register in EX.
- ex_mem_read  in  1  EX instruction is a load.
- branch_taken  in  1  EX/MEM branch resolved taken.
- mem_busy  in  1  data memory not ready this cycle.
- pc_load  out  1  PC register load.
- ifid_load  out  1  IF/ID load.
- idex_load  out  1  ID/EX load.
- exmem_load  out  1  EX/MEM load.
- memwb_load  out  1  MEM/WB load.
- ifid_flush  out  1  IF/ID captures a NOP.
- idex_flush  out  1  ID/EX captures a bubble.
- exmem_flush  out  1  EX/MEM captures a bubble.
- mem_timeout  out  1  sticky watchdog error.
- state  out  2  current FSM state, for debug.

Behaviour:
- States: INIT=0, RUN=1, WAIT=2, ERR=3. The FSM state and wait_cnt are the only registers; all other outputs are combinational from state and inputs.
- While rst=1:
  - state=INIT, wait_cnt=0, mem_timeout=0;
  - all *_load=0, all *_flush=1.
- INIT (first cycle after reset release):
  - all loads=1, all flushes=1, filling the pipe with bubbles;
  - next state RUN unconditionally.
- RUN, priority order: mem_busy > branch_taken > load-use.
  - mem_busy=1: all loads=0, all flushes=0; next WAIT; wait_cnt←1.
  - Else branch_taken=1: all loads=1; ifid_flush, idex_flush and exmem_flush=1. The 3 younger instructions are squashed in the same cycle and the PC takes the target. Any concurrent load-use is ignored.
  - Else load-use = ex_mem_read & (ex_rd≠0) & ((id_use_rs1 & ex_rd==id_rs1) | (id_use_rs2 & ex_rd==id_rs2)):
    - pc_load=0, ifid_load=0;
    - idex_load=1 with idex_flush=1 (one bubble);
    - exmem_load=1, memwb_load=1.
    - Exactly one stall cycle results, because the load advances and the condition clears.
  - Else: all loads=1, flushes=0.
- WAIT:
  - Whole pipeline frozen: all loads=0, flushes=0.
  - mem_busy=1 and wait_cnt==MAX_WAIT: next ERR; mem_timeout←1.
  - mem_busy=1 otherwise: wait_cnt increments.
  - mem_busy=0: next RUN; wait_cnt←0. Outputs this cycle follow the RUN rules (branch/load-use evaluated with frozen inputs), so a branch_taken held during the stall is applied on the exit cycle.
- ERR: all loads=0, flushes=0, mem_timeout=1. Held until rst.
- wait_cnt never wraps; saturation is impossible because ERR is entered first.
- Reset asserted mid-stall or in ERR returns the FSM to INIT asynchronously.

Optional Feature:
- Macro HAZARD_PERF_EN. When defined, adds outputs:
  - stall_cycles[31:0]: increments every cycle in WAIT, or in RUN with a load-use stall;
  - flush_events[31:0]: increments every cycle branch flushes are asserted.
- Both counters clear on rst and wrap at 2^32.
- When undefined, these ports and counters are absent and the rest of the behaviour is unchanged.

Decomposition:
- Shared package hazard_pkg holds:
  - state encoding constants (ST_INIT, ST_RUN, ST_WAIT, ST_ERR);
  - register-index width constant (5).
- One natural sub-module, hazard_detect: purely combinational load-use comparator producing load_use; instantiated once.

Test Plan:
- Reset then release: cycle 0 after release shows all loads=1, flushes=1, state=0; cycle 1 shows state=1 with flushes=0.
- ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 for one cycle: pc_load=0, ifid_load=0, idex_flush=1. The same pattern with ex_rd=0 gives no stall.
- branch_taken=1 together with a load-use match: pc_load=1; ifid_flush, idex_flush and exmem_flush=1; no stall.
- mem_busy high 4 cycles with branch_taken=1 throughout: 4 fully frozen cycles, then the exit cycle asserts the three flushes; mem_timeout stays 0.
- mem_busy held high with MAX_WAIT=16: state=3 and mem_timeout=1 after 17 busy cycles; it stays set after mem_busy drops, and clears only on rst.
- With HAZARD_PERF_EN defined: 2 load-use stalls, 3 wait cycles and 1 branch give stall_cycles=5 and flush_events=1.
